cache_refill_arbiter: RTL and testbench

Arbitrates cache-line refill reads from the ICache and DCache onto a single shared AXI read channel (AR/R) of AXI_DATA_WIDTH bits, so one 128-bit line moves in one beat. Sits between the two cache refill ports and the core's AXI master. One transaction is outstanding at a time. Round-robin fairness by default; DCache-priority mode is compile-time selectable.

---
 rtl/cache_refill_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cache_refill_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//
// Merges ICache and DCache line-refill reads onto one AXI read channel.
// A whole line (AXI_DATA_WIDTH bits) moves in a single beat and only one
// transaction is outstanding at a time. Ties between the two caches are
// broken round-robin, or with DCache priority when the build defines
// CACHE_REFILL_DCACHE_PRIORITY_EN.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   icache_req_* / dcache_req_*    refill request (valid/ready/addr)
//   icache_r* / dcache_r*          one-cycle response pulse with line data and error
//   axi_ar*                        AXI read-address channel (master side)
//   axi_r*                         AXI read-data channel (master side)
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      icache_req_valid,
    output logic                      icache_req_ready,
    input  logic [ADDR_WIDTH-1:0]     icache_req_addr,
    input  logic                      dcache_req_valid,
    output logic                      dcache_req_ready,
    input  logic [ADDR_WIDTH-1:0]     dcache_req_addr,
    output logic                      icache_rvalid,
    output logic [AXI_DATA_WIDTH-1:0] icache_rdata,
    output logic                      icache_rerr,
    output logic                      dcache_rvalid,
    output logic [AXI_DATA_WIDTH-1:0] dcache_rdata,
    output logic                      dcache_rerr,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [AXI_ID_WIDTH-1:0]   axi_arid,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    input  logic [AXI_ID_WIDTH-1:0]   axi_rid,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rlast
);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_t;

    state_t                    state;
    state_t                    state_next;
    logic                      owner;        // 0 = ICache, 1 = DCache
    logic [ADDR_WIDTH-5:0]     line_addr;    // line index, offset bits dropped
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      rerr_q;
    logic                      grant_dcache;
    logic                      accept;
    logic                      beat_match;
    logic [AXI_ID_WIDTH-1:0]   owner_id;
`ifndef CACHE_REFILL_DCACHE_PRIORITY_EN
    logic                      last_owner;
`endif

    // Single beat of a full line: length 0, 16-byte size, INCR.
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = 3'b100;
    assign axi_arburst = 2'b01;

    // rlast is implied by arlen = 0; address offset bits are never used.
    logic unused_ok;
    assign unused_ok = &{1'b0, axi_rlast, icache_req_addr[3:0], dcache_req_addr[3:0]};

    // Winner selection. A lone requester always wins; a tie goes to the
    // cache that was not served last (or always to DCache in priority mode).
    always_comb begin
`ifdef CACHE_REFILL_DCACHE_PRIORITY_EN
        grant_dcache = dcache_req_valid;
`else
        grant_dcache = dcache_req_valid && (!icache_req_valid || !last_owner);
`endif
    end

    assign accept           = (state == IDLE) && (icache_req_valid || dcache_req_valid);
    assign icache_req_ready = (state == IDLE) && icache_req_valid && !grant_dcache;
    assign dcache_req_ready = (state == IDLE) && grant_dcache;

    assign owner_id   = {{(AXI_ID_WIDTH-1){1'b0}}, owner};
    assign beat_match = axi_rvalid && (axi_rid == owner_id);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
`ifndef CACHE_REFILL_DCACHE_PRIORITY_EN
            last_owner <= 1'b1;
`endif
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= grant_dcache;
`ifndef CACHE_REFILL_DCACHE_PRIORITY_EN
                last_owner <= grant_dcache;
`endif
            end
        end
    end

    // Datapath registers need no reset: every output they feed is gated
    // by the FSM state, so they are invisible until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_addr <= grant_dcache ? dcache_req_addr[ADDR_WIDTH-1:4]
                                      : icache_req_addr[ADDR_WIDTH-1:4];
        end
        if ((state == R) && beat_match) begin
            rdata_q <= axi_rdata;
            rerr_q  <= (axi_rresp != 2'b00);
        end
    end

    always_comb begin
        state_next    = state;
        axi_arvalid   = 1'b0;
        axi_araddr    = '0;
        axi_arid      = '0;
        axi_rready    = 1'b0;
        icache_rvalid = 1'b0;
        icache_rdata  = '0;
        icache_rerr   = 1'b0;
        dcache_rvalid = 1'b0;
        dcache_rdata  = '0;
        dcache_rerr   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = AR;
            end
            AR: begin
                axi_arvalid = 1'b1;
                axi_araddr  = {line_addr, 4'b0000};
                axi_arid    = owner_id;
                if (axi_arready) state_next = R;
            end
            R: begin
                // Beats carrying another ID are accepted and dropped.
                axi_rready = 1'b1;
                if (beat_match) state_next = RESP;
            end
            RESP: begin
                if (owner) begin
                    dcache_rvalid = 1'b1;
                    dcache_rdata  = rdata_q;
                    dcache_rerr   = rerr_q;
                end else begin
                    icache_rvalid = 1'b1;
                    icache_rdata  = rdata_q;
                    icache_rerr   = rerr_q;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Testbench for cache_refill_arbiter: random requesters and an AXI slave
// with random latency and stray beats, checked by a transaction-level model
// and a response scoreboard.
module tb_cache_refill_arbiter;

    localparam int AW = 32;
    localparam int DW = 128;
    localparam int IW = 4;
`ifdef CACHE_REFILL_DCACHE_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          ic_v, dc_v;
    logic          ic_ready, dc_ready;
    logic [AW-1:0] ic_addr, dc_addr;
    logic          ic_rvalid, dc_rvalid;
    logic [DW-1:0] ic_rdata, dc_rdata;
    logic          ic_rerr, dc_rerr;
    logic          axi_arvalid, axi_arready;
    logic [AW-1:0] axi_araddr;
    logic [IW-1:0] axi_arid;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_rvalid, axi_rready;
    logic [DW-1:0] axi_rdata;
    logic [IW-1:0] axi_rid;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;

    cache_refill_arbiter #(.ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req_valid(ic_v), .icache_req_ready(ic_ready), .icache_req_addr(ic_addr),
        .dcache_req_valid(dc_v), .dcache_req_ready(dc_ready), .dcache_req_addr(dc_addr),
        .icache_rvalid(ic_rvalid), .icache_rdata(ic_rdata), .icache_rerr(ic_rerr),
        .dcache_rvalid(dc_rvalid), .dcache_rdata(dc_rdata), .dcache_rerr(dc_rerr),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model state ----------------
    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
        bit            err;
        int            due;
    } resp_t;

    resp_t         resp_q[$];
    logic [AW-1:0] ar_addr_q[$];
    bit            ar_own_q[$];
    int            grant_log[$];
    bit            busy_m, ar_phase, r_phase, resp_pend, last_m, cur_owner;
    bit            win, win_valid;
    logic [IW-1:0] slave_id;
    int            cyc_c = 0, cyc_m = 0;
    int            acc_cnt = 0, ic_acc_cnt = 0, dc_acc_cnt = 0;
    int            acc_cyc = 0, ar_cycles = 0;
    logic [AW-1:0] last_araddr;
    logic [IW-1:0] last_arid;
    int            resp_cnt = 0, resp_cyc = 0;
    bit            last_resp_owner, last_resp_err;

    // Slave behaviour knobs (-1 = random)
    int            ar_delay_fix = -1, r_delay_fix = -1, stray_fix = -1;
    int            stray_rid_fix = -1, rresp_fix = -1;
    bit            data_fix_en = 1'b0;
    logic [DW-1:0] data_fix = '0;

    // Request / AR / R checker: predicts grants and channel activity.
    initial begin
        forever begin
            @(negedge clk);
            cyc_c++;
            if (!rst_n) begin
                busy_m = 0; ar_phase = 0; r_phase = 0; resp_pend = 0; last_m = 1;
                ar_addr_q.delete(); ar_own_q.delete();
            end else begin
                win_valid = 1'b0;
                if (busy_m) begin
                    check("ready_busy", 128'({ic_ready, dc_ready}), 128'(2'b00));
                end else begin
                    win_valid = ic_v || dc_v;
                    if (ic_v && dc_v) win = PRIO ? 1'b1 : !last_m;
                    else              win = dc_v;
                    check("ready_idle", 128'({ic_ready, dc_ready}),
                          128'({win_valid && !win, win_valid && win}));
                    check("idle_ar_zero", 128'({axi_araddr, axi_arid}), 128'(0));
                end
                check("arvalid", 128'(axi_arvalid), 128'(ar_phase));
                check("rready", 128'(axi_rready), 128'(r_phase));
                if (axi_arvalid && ar_phase && ar_addr_q.size() > 0) begin
                    ar_cycles++;
                    last_araddr = axi_araddr;
                    last_arid   = axi_arid;
                    check("araddr", 128'(axi_araddr), 128'(ar_addr_q[0]));
                    check("arid", 128'(axi_arid), 128'(IW'(ar_own_q[0])));
                    check("ar_fixed", 128'({axi_arlen, axi_arsize, axi_arburst}),
                          128'({8'd0, 3'd4, 2'd1}));
                end
                if (resp_pend) begin
                    resp_pend = 0;
                    busy_m    = 0;
                end
                if (r_phase && axi_rvalid && axi_rid == slave_id) begin
                    r_phase   = 0;
                    resp_pend = 1;
                    resp_q.push_back('{cur_owner, axi_rdata, axi_rresp != 2'b00, cyc_c + 1});
                end
                if (ar_phase && axi_arready && ar_addr_q.size() > 0) begin
                    ar_phase = 0;
                    r_phase  = 1;
                    slave_id = IW'(ar_own_q[0]);
                    void'(ar_addr_q.pop_front());
                    void'(ar_own_q.pop_front());
                end
                if (win_valid) begin
                    busy_m    = 1;
                    ar_phase  = 1;
                    cur_owner = win;
                    last_m    = win;
                    ar_addr_q.push_back((win ? dc_addr : ic_addr) & ~32'hF);
                    ar_own_q.push_back(win);
                    grant_log.push_back(int'(win));
                    acc_cnt++;
                    if (win) dc_acc_cnt++; else ic_acc_cnt++;
                    acc_cyc   = cyc_c;
                    ar_cycles = 0;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a cache sees rvalid.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            cyc_m++;
            if (!rst_n) begin
                resp_q.delete();
                check("rst_outputs", 128'({ic_rvalid, dc_rvalid, axi_arvalid, axi_rready, ic_rerr, dc_rerr}),
                      128'(0));
            end else if (ic_rvalid || dc_rvalid) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rvalid i=%0b d=%0b required none", ic_rvalid, dc_rvalid);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_sel", 128'({ic_rvalid, dc_rvalid}), 128'(r.owner ? 2'b01 : 2'b10));
                    check("resp_data", r.owner ? dc_rdata : ic_rdata, r.data);
                    check("resp_err", 128'(r.owner ? dc_rerr : ic_rerr), 128'(r.err));
                    check("resp_time", 128'(cyc_m), 128'(r.due));
                    resp_cnt++;
                    resp_cyc        = cyc_m;
                    last_resp_owner = dc_rvalid;
                    last_resp_err   = r.owner ? dc_rerr : ic_rerr;
                end
            end else if (resp_q.size() > 0 && resp_q[0].due <= cyc_m) begin
                checks++;
                errors++;
                $display("FAIL missing_resp: got no rvalid required owner %0d", resp_q[0].owner);
                void'(resp_q.pop_front());
            end
        end
    end

    // AXI slave model
    initial begin
        bit ar_prev, r_prev;
        int arcnt, rcnt, ar_del, r_del, strays;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rid = '0; axi_rresp = '0; axi_rlast = 0;
        ar_prev = 0; r_prev = 0; arcnt = 0; rcnt = 0; ar_del = 0; r_del = 0; strays = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                axi_arready = 0; axi_rvalid = 0; ar_prev = 0; r_prev = 0;
            end else begin
                if (ar_phase) begin
                    if (!ar_prev) begin
                        ar_del = (ar_delay_fix >= 0) ? ar_delay_fix : int'($urandom_range(0, 3));
                        arcnt  = 0;
                    end
                    axi_arready = (arcnt >= ar_del);
                    arcnt++;
                end else begin
                    axi_arready = 0;
                end
                ar_prev = ar_phase;
                axi_rvalid = 0;
                if (r_phase) begin
                    if (!r_prev) begin
                        r_del  = (r_delay_fix >= 0) ? r_delay_fix : int'($urandom_range(0, 4));
                        strays = (stray_fix >= 0) ? stray_fix : int'($urandom_range(0, 2));
                        rcnt   = 0;
                    end
                    if (rcnt >= r_del) begin
                        axi_rvalid = 1;
                        axi_rlast  = 1;
                        if (strays > 0) begin
                            strays--;
                            axi_rid   = (stray_rid_fix >= 0) ? IW'(stray_rid_fix)
                                                             : slave_id ^ IW'($urandom_range(1, 15));
                            axi_rresp = 2'($urandom);
                            axi_rdata = {$urandom, $urandom, $urandom, $urandom};
                        end else begin
                            axi_rid   = slave_id;
                            axi_rdata = data_fix_en ? data_fix : {$urandom, $urandom, $urandom, $urandom};
                            axi_rresp = (rresp_fix >= 0) ? 2'(rresp_fix)
                                      : (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
                        end
                    end
                    rcnt++;
                end
                r_prev = r_phase;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 300) begin step(1); n++; end
        if (acc_cnt < target) begin
            checks++; errors++;
            $display("FAIL %s_accept_timeout: got %0d accepts required %0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_m && n < 300) begin step(1); n++; end
        if (busy_m) begin
            checks++; errors++;
            $display("FAIL %s_idle_timeout: got busy required idle", name);
        end
        step(1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        step(2);
        rst_n = 1;
    endtask

    task automatic set_modes(input int ard, input int rd, input int st);
        ar_delay_fix = ard; r_delay_fix = rd; stray_fix = st;
        stray_rid_fix = -1; rresp_fix = -1; data_fix_en = 0;
    endtask

    initial begin
        int base, rbase, ic_prev, dc_prev;
        rst_n = 0; ic_v = 0; dc_v = 0; ic_addr = '0; dc_addr = '0;
        step(2);
        check("reset_arvalid", 128'(axi_arvalid), 128'(0));
        check("reset_rready", 128'(axi_rready), 128'(0));
        check("reset_rvalid", 128'({ic_rvalid, dc_rvalid}), 128'(0));
        check("reset_rdata", ic_rdata | dc_rdata, 128'(0));
        check("reset_ar", 128'({axi_araddr, axi_arid}), 128'(0));
        rst_n = 1;
        step(1);

        // Single ICache refill with an immediate slave
        set_modes(0, 0, 0);
        data_fix_en = 1; data_fix = {16{8'hA5}}; rresp_fix = 0;
        ic_addr = 32'h1C00_0013; ic_v = 1;
        rbase = resp_cnt;
        wait_acc(acc_cnt + 1, "single");
        ic_v = 0;
        wait_idle("single");
        check("single_araddr", 128'(last_araddr), 128'(32'h1C00_0010));
        check("single_arid", 128'(last_arid), 128'(0));
        check("single_latency", 128'(resp_cyc - acc_cyc), 128'(3));
        check("single_owner", 128'({resp_cnt - rbase, 31'(0), last_resp_owner, last_resp_err}),
              128'({32'd1, 31'(0), 1'b0, 1'b0}));

        // Both requesting continuously from reset
        do_reset();
        set_modes(-1, -1, -1);
        base = acc_cnt;
        ic_v = 1; dc_v = 1; ic_addr = $urandom; dc_addr = $urandom;
        wait_acc(base + 4, "rr");
        ic_v = 0; dc_v = 0;
        wait_idle("rr");
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), 128'(grant_log[base + i]), 128'(PRIO ? 1 : (i % 2)));

        // Slow slave: arready after 5 cycles, data after 7
        set_modes(5, 7, 0);
        dc_addr = $urandom; dc_v = 1;
        wait_acc(acc_cnt + 1, "slow");
        dc_v = 0;
        wait_idle("slow");
        check("slow_ar_cycles", 128'(ar_cycles), 128'(6));

        // Stray beat with rid 3 ahead of an SLVERR response for DCache
        set_modes(0, 0, 1);
        stray_rid_fix = 3; rresp_fix = 2;
        dc_addr = $urandom; dc_v = 1;
        wait_acc(acc_cnt + 1, "stray");
        dc_v = 0;
        wait_idle("stray");
        check("stray_resp", 128'({last_resp_owner, last_resp_err}), 128'(2'b11));

        // Asynchronous reset while waiting for read data
        set_modes(0, 20, 0);
        ic_addr = $urandom; ic_v = 1;
        wait_acc(acc_cnt + 1, "rst_mid");
        ic_v = 0;
        begin
            int n = 0;
            while (!r_phase && n < 50) begin step(1); n++; end
        end
        step(2);
        @(posedge clk);
        #3 rst_n = 0;
        #1 check("async_rst_outs", 128'({axi_arvalid, axi_rready, ic_rvalid, dc_rvalid}), 128'(0));
        step(2);
        rst_n = 1;
        set_modes(-1, -1, -1);
        base = acc_cnt;
        ic_v = 1; dc_v = 1;
        wait_acc(base + 1, "post_rst");
        ic_v = 0; dc_v = 0;
        wait_idle("post_rst");
        check("post_rst_grant", 128'(grant_log[base]), 128'(PRIO ? 1 : 0));

        // DCache raises then drops its request while ICache is in flight
        set_modes(0, 10, 0);
        ic_addr = $urandom; ic_v = 1;
        wait_acc(acc_cnt + 1, "drop");
        ic_v = 0;
        base = acc_cnt;
        dc_addr = $urandom; dc_v = 1;
        step(3);
        dc_v = 0;
        wait_idle("drop");
        step(3);
        check("drop_no_accept", 128'(acc_cnt), 128'(base));

        // Randomized traffic
        set_modes(-1, -1, -1);
        base = acc_cnt; rbase = resp_cnt;
        ic_prev = ic_acc_cnt; dc_prev = dc_acc_cnt;
        for (int c = 0; c < 600; c++) begin
            if (ic_v) begin
                if (ic_acc_cnt != ic_prev) begin
                    if ($urandom_range(0, 1) == 1) ic_addr = $urandom; else ic_v = 0;
                end else if ($urandom_range(0, 7) == 0) ic_v = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                ic_v = 1; ic_addr = $urandom;
            end
            if (dc_v) begin
                if (dc_acc_cnt != dc_prev) begin
                    if ($urandom_range(0, 1) == 1) dc_addr = $urandom; else dc_v = 0;
                end else if ($urandom_range(0, 7) == 0) dc_v = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                dc_v = 1; dc_addr = $urandom;
            end
            ic_prev = ic_acc_cnt; dc_prev = dc_acc_cnt;
            step(1);
        end
        ic_v = 0; dc_v = 0;
        wait_idle("random");
        step(2);
        check("random_all_answered", 128'(resp_cnt - rbase), 128'(acc_cnt - base));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
